// File: rtl/if_fetch_pkg.sv
//============================================================================
// Module : if_fetch_pkg
// Brief  : Shared bus widths and FSM state encoding for the fetch stage.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef enum logic [0:0] {
        IF_FETCH = 1'b0,
        IF_HOLD  = 1'b1
    } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_fetch_icache.sv
//============================================================================
// Module : if_icache
// Brief  : Direct-mapped one-word-per-line instruction cache, combinational
//          lookup and single write port for line fill.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module if_icache
    import if_fetch_pkg::*;
#(
    parameter int LINES = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INST_ADDR_W-1:0] lookup_pc,
    output logic                   hit,
    output logic [INST_W-1:0]      word,
    input  logic                   fill_en,
    input  logic [INST_ADDR_W-1:0] fill_pc,
    input  logic [INST_W-1:0]      fill_word
);

    localparam int IDX_W = $clog2(LINES);
    // pc[1:0] is kept in the tag so an unaligned pc can never alias an aligned line.
    localparam int TAG_W = INST_ADDR_W - IDX_W;

    logic [LINES-1:0]  line_valid;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [INST_W-1:0] words [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = lookup_pc[2 +: IDX_W];
    assign wr_idx = fill_pc[2 +: IDX_W];
    assign rd_tag = {lookup_pc[INST_ADDR_W-1:2+IDX_W], lookup_pc[1:0]};
    assign wr_tag = {fill_pc[INST_ADDR_W-1:2+IDX_W], fill_pc[1:0]};

    assign hit  = line_valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign word = words[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_valid <= '0;
        end else if (fill_en) begin
            line_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[wr_idx]  <= wr_tag;
            words[wr_idx] <= fill_word;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
//============================================================================
// Module : if_fetch
// Brief  : Instruction fetch stage: PC, byte-wise word assembly, IF/ID outputs.
//          Optional direct-mapped I-cache enabled by macro IF_ICACHE_EN.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC     = 32'h0,
    parameter int                     ICACHE_LINES = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_i,
    input  logic                   br_flush_i,
    input  logic [INST_ADDR_W-1:0] br_addr_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [7:0]             mem_data_i,
    output logic                   valid_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_ADDR_W-1:0] npc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic [INST_ADDR_W-1:0] pred_o
);

    if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
        $error("ICACHE_LINES must be a power of two");
    end

    if_state_e              state, state_next;
    logic [INST_ADDR_W-1:0] pc;
    logic [1:0]             byte_cnt;
    logic [7:0]             lane0, lane1, lane2;
    // Holds mem_req_o low for the cycle after reset release or a redirect.
    logic                   req_block;
    logic                   hit;
    logic [INST_W-1:0]      cache_word;
    logic [INST_W-1:0]      word_asm;
    logic                   take_byte, take_hit, last_byte;

    assign word_asm = {mem_data_i, lane2, lane1, lane0};
    assign pred_o   = npc_o;

`ifdef IF_ICACHE_EN
    logic fill_en;
    assign fill_en = last_byte && !br_flush_i;

    if_icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup_pc (pc),
        .hit       (hit),
        .word      (cache_word),
        .fill_en   (fill_en),
        .fill_pc   (pc),
        .fill_word (word_asm)
    );
`else
    assign hit        = 1'b0;
    assign cache_word = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IF_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        take_byte  = 1'b0;
        take_hit   = 1'b0;
        last_byte  = 1'b0;
        if (state == IF_FETCH && !req_block) begin
            if (hit) begin
                take_hit = 1'b1;
            end else begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc + {30'd0, byte_cnt};
                take_byte  = mem_ack_i;
            end
        end
        last_byte = take_byte && (byte_cnt == 2'd3);
        case (state)
            IF_FETCH: if (take_hit || last_byte) state_next = IF_HOLD;
            IF_HOLD:  if (!stall_i) state_next = IF_FETCH;
            default:  state_next = IF_FETCH;
        endcase
        if (br_flush_i) state_next = IF_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            byte_cnt  <= 2'd0;
            lane0     <= 8'd0;
            lane1     <= 8'd0;
            lane2     <= 8'd0;
            req_block <= 1'b1;
            valid_o   <= 1'b0;
            pc_o      <= '0;
            npc_o     <= '0;
            inst_o    <= '0;
        end else begin
            req_block <= 1'b0;
            if (br_flush_i) begin
                pc        <= br_addr_i;
                byte_cnt  <= 2'd0;
                req_block <= 1'b1;
                valid_o   <= 1'b0;
                inst_o    <= '0;
            end else if (take_hit || last_byte) begin
                valid_o  <= 1'b1;
                inst_o   <= take_hit ? cache_word : word_asm;
                pc_o     <= pc;
                npc_o    <= pc + 32'd4;
                pc       <= pc + 32'd4;
                byte_cnt <= 2'd0;
            end else if (take_byte) begin
                case (byte_cnt)
                    2'd0:    lane0 <= mem_data_i;
                    2'd1:    lane1 <= mem_data_i;
                    default: lane2 <= mem_data_i;
                endcase
                byte_cnt <= byte_cnt + 2'd1;
            end else if (state == IF_HOLD && !stall_i) begin
                valid_o <= 1'b0;
                inst_o  <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
//============================================================================
// Module : tb_if_fetch
// Brief  : Directed self-checking bench for if_fetch.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_flush_i = 1'b0;
    logic [31:0] br_addr_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_data_i = '0;
    logic        valid_o;
    logic [31:0] pc_o, npc_o, inst_o, pred_o;

    int passed = 0;
    int total  = 0;

    if_fetch #(.RESET_PC(32'h0), .ICACHE_LINES(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .br_flush_i (br_flush_i),
        .br_addr_i  (br_addr_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .valid_o    (valid_o),
        .pc_o       (pc_o),
        .npc_o      (npc_o),
        .inst_o     (inst_o),
        .pred_o     (pred_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] npc, input logic [31:0] inst);
        check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
        check({tag, ".pc"},    pc_o,   pc);
        check({tag, ".npc"},   npc_o,  npc);
        check({tag, ".pred"},  pred_o, npc);
        check({tag, ".inst"},  inst_o, inst);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req_o && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req_o) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_one(input logic [31:0] addr, input logic [7:0] d);
        wait_req();
        check("req_addr", mem_addr_o, addr);
        mem_ack_i  = 1'b1;
        mem_data_i = d;
        tick();
        mem_ack_i  = 1'b0;
    endtask

    task automatic fetch_word(input logic [31:0] base, input logic [31:0] w);
        ack_one(base,         w[7:0]);
        ack_one(base + 32'd1, w[15:8]);
        ack_one(base + 32'd2, w[23:16]);
        ack_one(base + 32'd3, w[31:24]);
        check_outs("fetch", 1'b1, base, base + 32'd4, w);
        check("hold_req", {31'd0, mem_req_o}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_outs("reset", 1'b0, 32'h0, 32'h0, 32'h0);
        check("reset_req",  {31'd0, mem_req_o}, 32'd0);
        check("reset_addr", mem_addr_o, 32'h0);
        rst_n = 1'b1;
        tick();
        check("first_req", {31'd0, mem_req_o}, 32'd1);

        // Basic fetch of 0x00100513 from address 0
        fetch_word(32'h0, 32'h00100513);

        // Stall holds everything
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs("stall", 1'b1, 32'h0, 32'h4, 32'h00100513);
            check("stall_req", {31'd0, mem_req_o}, 32'd0);
        end
        stall_i = 1'b0;
        tick();
        check("consume_valid", {31'd0, valid_o}, 32'd0);
        check("consume_inst",  inst_o, 32'h0);
        check("next_req",      {31'd0, mem_req_o}, 32'd1);
        check("next_addr",     mem_addr_o, 32'h4);

        // Flush coincident with byte-2 ack
        ack_one(32'h4, 8'hAA);
        ack_one(32'h5, 8'hBB);
        check("b2_addr", mem_addr_o, 32'h6);
        mem_ack_i  = 1'b1;
        mem_data_i = 8'hCC;
        br_flush_i = 1'b1;
        br_addr_i  = 32'h100;
        tick();
        mem_ack_i  = 1'b0;
        br_flush_i = 1'b0;
        check("flush_req",   {31'd0, mem_req_o}, 32'd0);
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_inst",  inst_o, 32'h0);
        tick();
        check("redir_req",  {31'd0, mem_req_o}, 32'd1);
        check("redir_addr", mem_addr_o, 32'h100);
        fetch_word(32'h100, 32'h00100093);
        tick();
        fetch_word(32'h104, 32'h00001237);

        // Flush together with stall: flush wins
        stall_i    = 1'b1;
        br_flush_i = 1'b1;
        br_addr_i  = 32'hFFFFFFFC;
        tick();
        stall_i    = 1'b0;
        br_flush_i = 1'b0;
        check("fs_valid", {31'd0, valid_o}, 32'd0);
        check("fs_inst",  inst_o, 32'h0);
        check("fs_req",   {31'd0, mem_req_o}, 32'd0);
        tick();

        // Address wrap at top of memory
        fetch_word(32'hFFFFFFFC, 32'h0000006F);
        tick();
`ifdef IF_ICACHE_EN
        check("hit_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        check_outs("hit", 1'b1, 32'h0, 32'h4, 32'h00100513);
        check("hit_req2", {31'd0, mem_req_o}, 32'd0);
`else
        check("wrap_req",  {31'd0, mem_req_o}, 32'd1);
        check("wrap_addr", mem_addr_o, 32'h0);
        fetch_word(32'h0, 32'h00100513);
`endif
        tick();

        // Asynchronous reset in the middle of a fetch
        ack_one(32'h4, 8'h13);
        check("mid_addr", mem_addr_o, 32'h5);
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 32'h0, 32'h0, 32'h0);
        check("async_rst_req",  {31'd0, mem_req_o}, 32'd0);
        check("async_rst_addr", mem_addr_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        fetch_word(32'h0, 32'h00100513);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
